direction_turn_scheduler: RTL and testbench
===========================================

Name: direction_turn_scheduler

Overview:
- Sits between the four board buttons and the snake movement/position logic.
- Conditions the raw buttons and queues legal turn requests.
- Releases at most one queued turn per game movement tick, so quick multi-button sequences (e.g. RIGHT then DOWN inside one tick) are not lost or collapsed into a reversal.
- Its output DIR_OUT is the authoritative current direction for the snake datapath.

Parameters:
- DEBOUNCE_CYCLES, 16'd50000: number of consecutive stable synchronised samples required before a button level is accepted.
- QUEUE_DEPTH, 2: number of pending turn entries. Legal values are 1 to 4.
- CNT_W, 16: width of the debounce counter. The design requires CNT_W ≥ clog2(DEBOUNCE_CYCLES+1).

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- BTNL  in  1  raw left button, asynchronous
- BTNT  in  1  raw top button, asynchronous
- BTNR  in  1  raw right button, asynchronous
- BTND  in  1  raw down button, asynchronous
- MOVE_TICK  in  1  single-cycle pulse from the game timer; one snake step
- ENABLE  in  1  high while the game is running
- DIR_OUT  out  2  current direction: 0=UP, 1=RIGHT, 2=DOWN, 3=LEFT
- TURN_APPLIED  out  1  single-cycle pulse, aligned with the DIR_OUT update
- QUEUE_COUNT  out  3  number of pending entries
- OVERFLOW  out  1  sticky; set when a legal turn is dropped because the queue is full

Behaviour:
- Reset: clocked by CLK, synchronous, active-high.
  - DIR_OUT=0 (UP), TURN_APPLIED=0, QUEUE_COUNT=0, OVERFLOW=0.
  - Synchronisers, debounce counters and accepted levels are all cleared.
  - Reset asserted mid-operation discards queued turns and any debounce in progress.
- Conditioning, per button:
  - 2-flop synchroniser.
  - Debounce counter reloads whenever the synchronised level differs from the accepted level. After DEBOUNCE_CYCLES consecutive differing samples, the accepted level toggles.
  - A 0→1 toggle of the accepted level produces a one-cycle press pulse.
  - Holding a button yields exactly one press.
- Press arbitration: when several press pulses occur in the same cycle, priority is T > R > D > L. Lower-priority presses in that cycle are discarded.
- Reference direction = newest queued entry if QUEUE_COUNT>0, otherwise DIR_OUT.
- Legality: a candidate is legal only if it is perpendicular to the reference, i.e. (cand XOR ref)[0]==1.
  - Same direction or reversal (cand == ref XOR 2) is silently dropped.
  - OVERFLOW is not set for these drops.
- Push: a legal candidate is written at the tail.
  - If the queue is full and there is no pop in the same cycle, the candidate is dropped and OVERFLOW is set.
- Pop: on MOVE_TICK && ENABLE && QUEUE_COUNT>0.
  - The head is written to DIR_OUT and TURN_APPLIED pulses on the following cycle.
  - On MOVE_TICK with an empty queue, DIR_OUT holds and there is no pulse.
- Simultaneous push and pop:
  - Legality is evaluated against the pre-pop reference.
  - Push is accepted even when the queue is full (the pop frees a slot).
  - QUEUE_COUNT is unchanged.
- ENABLE low:
  - Queue is flushed (count→0) on the next cycle.
  - Presses are ignored and MOVE_TICK is ignored.
  - DIR_OUT holds. Conditioning keeps running so held buttons do not fire on enable.
- Latency:
  - Raw edge to press pulse: 2 + DEBOUNCE_CYCLES cycles.
  - Press pulse to queue entry: 1 cycle.
  - MOVE_TICK to DIR_OUT update: 1 cycle.
- Queue storage: circular buffer with read/write pointers that wrap modulo QUEUE_DEPTH, plus an explicit count register. Full = (count==QUEUE_DEPTH).

Decomposition:
- Shared package snake_nav_pkg:
  - direction encoding constants DIR_UP/RIGHT/DOWN/LEFT.
  - 2-bit direction type.
  - functions opposite(d) = d XOR 2 and is_perpendicular(a,b).
- Sub-module button_conditioner (synchroniser + debounce + rising-edge pulse), parameterised by DEBOUNCE_CYCLES/CNT_W and instantiated four times.

Test Plan (bench uses DEBOUNCE_CYCLES=4, QUEUE_DEPTH=2):
- After reset, hold BTNR for 10 cycles, then pulse MOVE_TICK → QUEUE_COUNT 0→1 exactly 7 cycles after the raw edge; DIR_OUT=1 and TURN_APPLIED=1 one cycle after the tick; no second entry while BTNR stays held.
- DIR_OUT=0: press BTND, then BTNT → both dropped; QUEUE_COUNT stays 0, OVERFLOW=0.
- DIR_OUT=0: press R, then D, then L with no tick → queue holds {1,2}; L dropped with OVERFLOW=1. Two ticks then give DIR_OUT 1 then 2, each with a TURN_APPLIED pulse.
- DIR_OUT=1, queue empty: BTNT and BTNL debounced in the same cycle → only UP (0) queued; QUEUE_COUNT=1.
- Queue full {0,3} with DIR_OUT=1: a legal DOWN press lands in the MOVE_TICK cycle → DIR_OUT=0, queue becomes {3,2}, count stays 2, OVERFLOW unchanged.
- Queue count 2, then ENABLE low → count=0 next cycle, ticks ignored, DIR_OUT unchanged. Then assert RESET mid-debounce → all outputs return to their reset values and no press is emitted afterward.

Source files
------------

// File: rtl/snake_nav_pkg.sv
// Shared snake navigation types: direction encoding and
// the direction helper functions.
package snake_nav_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_RIGHT = 2'd1;
  localparam dir_t DIR_DOWN  = 2'd2;
  localparam dir_t DIR_LEFT  = 2'd3;

  localparam int unsigned MAX_DEPTH = 4;

  function automatic dir_t opposite(dir_t d);
    return d ^ 2'd2;
  endfunction

  function automatic logic is_perpendicular(dir_t a, dir_t b);
    dir_t x;
    x = a ^ b;
    return x[0];
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// One button: 2-flop synchroniser, stability debounce
// and a single-cycle pulse on each accepted press.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W = 16
) (
  input  logic CLK,
  input  logic RESET,
  input  logic btn_i,
  output logic press_o
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != acc_q) begin
      if (cnt_q == LAST) begin
        acc_d   = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/direction_turn_scheduler.sv
// Conditions the four buttons and queues perpendicular
// turns, releasing at most one per movement tick.
module direction_turn_scheduler
  import snake_nav_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16'd50000,
  parameter int unsigned QUEUE_DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BTNL,
  input  logic       BTNT,
  input  logic       BTNR,
  input  logic       BTND,
  input  logic       MOVE_TICK,
  input  logic       ENABLE,
  output logic [1:0] DIR_OUT,
  output logic       TURN_APPLIED,
  output logic [2:0] QUEUE_COUNT,
  output logic       OVERFLOW
);

  typedef logic [1:0] ptr_t;

  localparam ptr_t       PTR_LAST = 2'(QUEUE_DEPTH - 1);
  localparam logic [2:0] FULL_CNT = 3'(QUEUE_DEPTH);

  logic p_l, p_t, p_r, p_d;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W))
    u_btn_l (.CLK(CLK), .RESET(RESET), .btn_i(BTNL), .press_o(p_l));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W))
    u_btn_t (.CLK(CLK), .RESET(RESET), .btn_i(BTNT), .press_o(p_t));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W))
    u_btn_r (.CLK(CLK), .RESET(RESET), .btn_i(BTNR), .press_o(p_r));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W))
    u_btn_d (.CLK(CLK), .RESET(RESET), .btn_i(BTND), .press_o(p_d));

  function automatic ptr_t wrap_inc(ptr_t p);
    return (p == PTR_LAST) ? 2'd0 : p + 2'd1;
  endfunction

  dir_t       mem_q [MAX_DEPTH];
  ptr_t       wr_q, wr_d, rd_q, rd_d;
  logic [2:0] cnt_q, cnt_d;
  dir_t       dir_q, dir_d;
  logic       turn_q, turn_d;
  logic       ovf_q, ovf_d;

  dir_t cand, ref_dir;
  ptr_t newest;
  logic cand_v, legal, full, push, pop;

  // Several presses in one cycle: keep only the highest priority.
  always_comb begin
    cand_v = 1'b1;
    cand   = DIR_UP;
    priority case (1'b1)
      p_t:     cand = DIR_UP;
      p_r:     cand = DIR_RIGHT;
      p_d:     cand = DIR_DOWN;
      p_l:     cand = DIR_LEFT;
      default: cand_v = 1'b0;
    endcase
  end

  always_comb begin
    newest  = (wr_q == 2'd0) ? PTR_LAST : wr_q - 2'd1;
    ref_dir = (cnt_q != 3'd0) ? mem_q[newest] : dir_q;
    full    = (cnt_q == FULL_CNT);
    pop     = ENABLE && MOVE_TICK && (cnt_q != 3'd0);
    legal   = ENABLE && cand_v && is_perpendicular(cand, ref_dir);
    push    = legal && (!full || pop);
  end

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    turn_d = 1'b0;
    ovf_d  = ovf_q;
    if (!ENABLE) begin
      wr_d  = 2'd0;
      rd_d  = 2'd0;
      cnt_d = 3'd0;
    end else begin
      if (pop) begin
        dir_d  = mem_q[rd_q];
        turn_d = 1'b1;
        rd_d   = wrap_inc(rd_q);
      end
      if (push)
        wr_d = wrap_inc(wr_q);
      if (legal && full && !pop)
        ovf_d = 1'b1;
      if (push && !pop)
        cnt_d = cnt_q + 3'd1;
      else if (pop && !push)
        cnt_d = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_q   <= 2'd0;
      rd_q   <= 2'd0;
      cnt_q  <= 3'd0;
      dir_q  <= DIR_UP;
      turn_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      turn_q <= turn_d;
      ovf_q  <= ovf_d;
      if (push)
        mem_q[wr_q] <= cand;
    end
  end

  assign DIR_OUT      = dir_q;
  assign TURN_APPLIED = turn_q;
  assign QUEUE_COUNT  = cnt_q;
  assign OVERFLOW     = ovf_q;

endmodule

// File: tb/tb_direction_turn_scheduler.sv
// Directed bench for direction_turn_scheduler with a short
// debounce window and a two-entry queue.
module tb_direction_turn_scheduler;

  logic       CLK = 1'b0;
  logic       RESET, BTNL, BTNT, BTNR, BTND;
  logic       MOVE_TICK, ENABLE;
  logic [1:0] DIR_OUT;
  logic       TURN_APPLIED;
  logic [2:0] QUEUE_COUNT;
  logic       OVERFLOW;

  int checks = 0;
  int errors = 0;

  direction_turn_scheduler #(
    .DEBOUNCE_CYCLES(4),
    .QUEUE_DEPTH(2),
    .CNT_W(16)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .BTNL(BTNL), .BTNT(BTNT), .BTNR(BTNR), .BTND(BTND),
    .MOVE_TICK(MOVE_TICK), .ENABLE(ENABLE),
    .DIR_OUT(DIR_OUT), .TURN_APPLIED(TURN_APPLIED),
    .QUEUE_COUNT(QUEUE_COUNT), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] btn;  // {T,R,D,L}
    logic       tick;
    int         hold;
    int         dir;
    int         cnt;
    int         ovf;
    int         turn;
  } vec_t;

  vec_t vecs [13];

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input int d, input int c,
                         input int o, input int t);
    chk({name, ".dir"}, int'(DIR_OUT), d);
    chk({name, ".cnt"}, int'(QUEUE_COUNT), c);
    chk({name, ".ovf"}, int'(OVERFLOW), o);
    chk({name, ".turn"}, int'(TURN_APPLIED), t);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step(2);
    RESET = 1'b0;
    step(1);
  endtask

  task automatic tick();
    MOVE_TICK = 1'b1;
    step(1);
    MOVE_TICK = 1'b0;
  endtask

  task automatic press(input logic [3:0] b);
    {BTNT, BTNR, BTND, BTNL} = b;
    step(8);
    {BTNT, BTNR, BTND, BTNL} = 4'b0;
    step(7);
  endtask

  initial begin
    vecs[0]  = '{4'b0010, 1'b0, 8, 0, 0, 0, 0};
    vecs[1]  = '{4'b0000, 1'b0, 7, 0, 0, 0, 0};
    vecs[2]  = '{4'b1000, 1'b0, 8, 0, 0, 0, 0};
    vecs[3]  = '{4'b0000, 1'b0, 7, 0, 0, 0, 0};
    vecs[4]  = '{4'b0100, 1'b0, 8, 0, 1, 0, 0};
    vecs[5]  = '{4'b0000, 1'b0, 7, 0, 1, 0, 0};
    vecs[6]  = '{4'b0010, 1'b0, 8, 0, 2, 0, 0};
    vecs[7]  = '{4'b0000, 1'b0, 7, 0, 2, 0, 0};
    vecs[8]  = '{4'b0001, 1'b0, 8, 0, 2, 1, 0};
    vecs[9]  = '{4'b0000, 1'b0, 7, 0, 2, 1, 0};
    vecs[10] = '{4'b0000, 1'b1, 1, 1, 1, 1, 1};
    vecs[11] = '{4'b0000, 1'b1, 1, 2, 0, 1, 1};
    vecs[12] = '{4'b0000, 1'b1, 2, 2, 0, 1, 0};

    RESET = 1'b1;
    {BTNT, BTNR, BTND, BTNL} = 4'b0;
    MOVE_TICK = 1'b0;
    ENABLE = 1'b1;
    step(3);
    RESET = 1'b0;
    step(1);
    chk_all("reset", 0, 0, 0, 0);

    // Hold RIGHT: entry appears exactly 7 cycles after the raw edge.
    BTNR = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step(1);
      if (k == 6) chk("lat6.cnt", int'(QUEUE_COUNT), 0);
      if (k == 7) chk("lat7.cnt", int'(QUEUE_COUNT), 1);
    end
    step(3);
    chk("held.cnt", int'(QUEUE_COUNT), 1);
    tick();
    chk_all("tick1", 1, 0, 0, 1);
    step(1);
    chk("tick1.pulse_end", int'(TURN_APPLIED), 0);
    BTNR = 1'b0;
    step(8);

    // Table: reversal/same drops, queue fill, overflow, drains.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      {BTNT, BTNR, BTND, BTNL} = vecs[i].btn;
      MOVE_TICK = vecs[i].tick;
      step(1);
      MOVE_TICK = 1'b0;
      step(vecs[i].hold - 1);
      chk_all($sformatf("vec%0d", i), vecs[i].dir, vecs[i].cnt,
              vecs[i].ovf, vecs[i].turn);
    end
    {BTNT, BTNR, BTND, BTNL} = 4'b0;

    // Simultaneous TOP and LEFT presses with DIR_OUT=RIGHT.
    do_reset();
    chk_all("reset2", 0, 0, 0, 0);
    press(4'b0100);
    tick();
    chk("arb.pre_dir", int'(DIR_OUT), 1);
    press(4'b1001);
    chk("arb.cnt", int'(QUEUE_COUNT), 1);
    tick();
    chk_all("arb.pop", 0, 0, 0, 1);

    // Full queue {UP,LEFT}, DOWN push lands on the tick cycle.
    do_reset();
    press(4'b0100);
    tick();
    press(4'b1000);
    press(4'b0001);
    chk_all("full", 1, 2, 0, 0);
    BTND = 1'b1;
    step(6);
    tick();
    chk_all("pushpop", 0, 2, 0, 1);
    BTND = 1'b0;
    step(7);
    tick();
    chk("drain1.dir", int'(DIR_OUT), 3);
    step(1);
    tick();
    chk_all("drain2", 2, 0, 0, 1);

    // ENABLE low flushes and ignores ticks.
    press(4'b0100);
    press(4'b0010);
    chk("pre_flush.cnt", int'(QUEUE_COUNT), 2);
    ENABLE = 1'b0;
    step(1);
    chk("flush.cnt", int'(QUEUE_COUNT), 0);
    tick();
    chk_all("dis_tick", 2, 0, 0, 0);
    ENABLE = 1'b1;
    step(2);

    // Reset in the middle of a debounce.
    BTNR = 1'b1;
    step(3);
    RESET = 1'b1;
    BTNR = 1'b0;
    step(1);
    chk_all("mid_reset", 0, 0, 0, 0);
    RESET = 1'b0;
    step(10);
    chk_all("post_reset", 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
